// File: rtl/step_clock_if.sv
// Button, halt and step-strobe signals exchanged between the board/datapath side
// (master) and the run/step controller (slave).
interface step_clock_if;
    logic        BtnStep;
    logic        BtnRun;
    logic        Halt;
    logic        ClkEn;
    logic        Running;
    logic [15:0] StepCount;

    modport master (
        output BtnStep, BtnRun, Halt,
        input  ClkEn, Running, StepCount
    );

    modport slave (
        input  BtnStep, BtnRun, Halt,
        output ClkEn, Running, StepCount
    );
endinterface

// File: rtl/step_clock_ctrl.sv
// Run/step controller: debounces the Step and Run buttons and issues a one-cycle
// datapath clock enable, either per Step press (PAUSE) or every DIV_COUNT cycles (RUN).
module step_clock_ctrl #(
    parameter int DIV_COUNT       = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    step_clock_if.slave  bus
);

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is the Step button, bit 1 the Run button.
    logic [1:0] raw_s;
    logic [1:0] press_s;

    assign raw_s = {bus.BtnRun, bus.BtnStep};

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic             sync1_r;
        logic             sync2_r;
        logic             level_r;
        logic             level_d_r;
        logic [CNT_W-1:0] cnt_r;

        // Synchronize the raw button and accept a new level after a full run of differing samples.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                sync1_r   <= 1'b0;
                sync2_r   <= 1'b0;
                level_r   <= 1'b0;
                level_d_r <= 1'b0;
                cnt_r     <= '0;
            end else begin
                sync1_r   <= raw_s[i];
                sync2_r   <= sync1_r;
                level_d_r <= level_r;
                if (sync2_r == level_r) begin
                    cnt_r <= '0;
                end else if (cnt_r == DEB_LAST) begin
                    level_r <= ~level_r;
                    cnt_r   <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
        end

        assign press_s[i] = level_r & ~level_d_r;
    end

    state_t           state_r, state_s;
    logic [CNT_W-1:0] presc_r, presc_s;
    logic             clk_en_r, clk_en_s;
    logic             running_r;
    logic [15:0]      count_r;

    // Next-state and strobe decode; Halt overrides everything and drops presses on the floor.
    always_comb begin
        state_s  = state_r;
        presc_s  = presc_r;
        clk_en_s = 1'b0;
        if (bus.Halt) begin
            state_s = PAUSE;
            presc_s = '0;
        end else begin
            case (state_r)
                PAUSE: begin
                    if (press_s[1]) begin
                        state_s = RUN;
                        presc_s = '0;
                    end else if (press_s[0]) begin
                        clk_en_s = 1'b1;
                    end else begin
                        state_s = PAUSE;
                    end
                end
                RUN: begin
                    if (press_s[1]) begin
                        state_s = PAUSE;
                        presc_s = '0;
                    end else if (presc_r == PRESC_LAST) begin
                        clk_en_s = 1'b1;
                        presc_s  = '0;
                    end else begin
                        presc_s = presc_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = PAUSE;
                    presc_s = '0;
                end
            endcase
        end
    end

    // State, prescaler and registered outputs; StepCount advances with each issued strobe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r   <= PAUSE;
            presc_r   <= '0;
            clk_en_r  <= 1'b0;
            running_r <= 1'b0;
            count_r   <= 16'h0000;
        end else begin
            state_r   <= state_s;
            presc_r   <= presc_s;
            clk_en_r  <= clk_en_s;
            running_r <= (state_s == RUN);
            if (clk_en_s) begin
                count_r <= count_r + 16'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign bus.ClkEn     = clk_en_r;
    assign bus.Running   = running_r;
    assign bus.StepCount = count_r;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Self-checking bench for step_clock_ctrl: directed scenarios plus randomized button/halt
// traffic compared against a sliding-window behavioural model.
module tb_step_clock_ctrl;

    localparam int DIV  = 5;
    localparam int DEB  = 4;
    localparam int MAXH = 8192;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    step_clock_if bus ();
    step_clock_if bus2 ();

    step_clock_ctrl #(.DIV_COUNT(DIV), .DEBOUNCE_CYCLES(DEB), .CNT_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus.slave)
    );

    step_clock_ctrl #(.DIV_COUNT(1), .DEBOUNCE_CYCLES(1), .CNT_W(8)) dut_fast (
        .Clk(Clk), .Reset(Reset), .bus(bus2.slave)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    bit          hist [0:1][0:MAXH-1];
    bit          lvl [0:1];
    bit          pv [0:1];
    bit          m_run;
    bit          m_clken;
    logic [15:0] m_count;
    int          run_start;
    int          edge_n;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            lvl[b] = 1'b0;
            pv[b]  = 1'b0;
        end
        m_run     = 1'b0;
        m_clken   = 1'b0;
        m_count   = 16'h0000;
        run_start = 0;
        edge_n    = 0;
    endtask

    function automatic bit samp(input int b, input int idx);
        return (idx < 0) ? 1'b0 : hist[b][idx];
    endfunction

    // Apply the behavioural rules for one clock edge.
    task automatic model_edge();
        bit ce;
        bit all_diff;
        ce = 1'b0;
        if (bus.Halt) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            if (pv[1]) begin
                m_run     = 1'b1;
                run_start = edge_n;
            end else if (pv[0]) begin
                ce = 1'b1;
            end
        end else begin
            if (pv[1]) m_run = 1'b0;
            else if (((edge_n - run_start) % DIV) == 0) ce = 1'b1;
        end
        m_clken = ce;
        if (ce) m_count = m_count + 16'd1;
        hist[0][edge_n] = bus.BtnStep;
        hist[1][edge_n] = bus.BtnRun;
        // Debounced level flips once the last DEB synchronized samples all disagree with it.
        for (int b = 0; b < 2; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (samp(b, edge_n - 2 - j) == lvl[b]) all_diff = 1'b0;
            pv[b] = all_diff & ~lvl[b];
            if (all_diff) lvl[b] = ~lvl[b];
        end
        edge_n++;
    endtask

    task automatic cyc();
        @(posedge Clk);
        model_edge();
        #1;
        chk("clken_model", bus.ClkEn, m_clken);
        chk("running_model", bus.Running, m_run);
        chk("count_model", bus.StepCount, m_count);
    endtask

    task automatic cycles(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (bus.ClkEn) pulses++;
        end
    endtask

    initial begin
        int pulses;
        int seen;
        int n;
        int hold_s;
        int hold_r;
        int ones;
        bus.BtnStep  = 1'b0;
        bus.BtnRun   = 1'b0;
        bus.Halt     = 1'b0;
        bus2.BtnStep = 1'b0;
        bus2.BtnRun  = 1'b0;
        bus2.Halt    = 1'b0;
        model_reset();

        // 1: reset values, then idle
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_clken", bus.ClkEn, 1'b0);
        chk("reset_running", bus.Running, 1'b0);
        chk("reset_count", bus.StepCount, 16'd0);
        Reset = 1'b0;
        model_reset();
        cycles(20, pulses);
        chk("idle_pulses", pulses, 0);

        // 2: held Step gives one strobe, in the cycle after edge DEB+2
        bus.BtnStep = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("step_latency", bus.ClkEn, (i == DEB + 2) ? 1'b1 : 1'b0);
        end
        bus.BtnStep = 1'b0;
        cycles(10, pulses);
        chk("step_count1", bus.StepCount, 16'd1);

        // 3: short glitches are rejected
        for (int k = 0; k < 5; k++) begin
            bus.BtnStep = 1'b1;
            cycles(3, pulses);
            chk("glitch_hi", pulses, 0);
            bus.BtnStep = 1'b0;
            cycles(3, pulses);
            chk("glitch_lo", pulses, 0);
        end
        chk("glitch_count", bus.StepCount, 16'd1);

        // 4: RUN mode, 12 strobes, then pause
        bus.BtnRun = 1'b1;
        cycles(8, pulses);
        bus.BtnRun = 1'b0;
        seen = pulses;
        n = 0;
        while (seen < 12 && n < 200) begin
            cyc();
            if (bus.ClkEn) seen++;
            n++;
        end
        chk("run_pulses", seen, 12);
        chk("run_count", bus.StepCount, 16'd13);
        chk("run_running", bus.Running, 1'b1);
        bus.BtnRun = 1'b1;
        cycles(8, pulses);
        bus.BtnRun = 1'b0;
        cycles(10, pulses);
        chk("pause_running", bus.Running, 1'b0);
        cycles(20, pulses);
        chk("pause_pulses", pulses, 0);

        // 6: Halt in RUN, Step during Halt, Step after Halt
        bus.BtnRun = 1'b1;
        cycles(8, pulses);
        bus.BtnRun = 1'b0;
        cycles(6, pulses);
        chk("halt_pre_running", bus.Running, 1'b1);
        bus.Halt = 1'b1;
        cyc();
        chk("halt_running", bus.Running, 1'b0);
        chk("halt_clken", bus.ClkEn, 1'b0);
        bus.Halt = 1'b0;
        cycles(10, pulses);
        chk("halt_no_resume", pulses, 0);
        bus.Halt = 1'b1;
        bus.BtnStep = 1'b1;
        cycles(9, pulses);
        bus.BtnStep = 1'b0;
        cycles(9, n);
        chk("halt_step_drop", pulses + n, 0);
        bus.Halt = 1'b0;
        cycles(10, pulses);
        chk("halt_no_queue", pulses, 0);
        bus.BtnStep = 1'b1;
        cycles(9, pulses);
        bus.BtnStep = 1'b0;
        cycles(9, n);
        chk("post_halt_step", pulses + n, 1);

        // 7: reset during a half-debounced press; held button presses once after reset
        bus.BtnStep = 1'b1;
        cycles(3, pulses);
        Reset = 1'b1;
        #1;
        chk("midreset_clken", bus.ClkEn, 1'b0);
        chk("midreset_count", bus.StepCount, 16'd0);
        chk("midreset_running", bus.Running, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("reheld_latency", bus.ClkEn, (i == DEB + 2) ? 1'b1 : 1'b0);
        end
        bus.BtnStep = 1'b0;
        cycles(8, pulses);
        chk("reheld_count", bus.StepCount, 16'd1);

        // Randomized buttons and halt against the model
        hold_s = 0;
        hold_r = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold_s == 0) begin
                bus.BtnStep = 1'($urandom_range(0, 1));
                hold_s = $urandom_range(1, 12);
            end else begin
                hold_s--;
            end
            if (hold_r == 0) begin
                bus.BtnRun = ($urandom_range(0, 3) == 0);
                hold_r = $urandom_range(1, 30);
            end else begin
                hold_r--;
            end
            bus.Halt = ($urandom_range(0, 31) == 0);
            cyc();
        end
        bus.BtnStep = 1'b0;
        bus.BtnRun  = 1'b0;
        bus.Halt    = 1'b0;

        // 5: DIV_COUNT=1 strobes every cycle; StepCount wraps after 65536 strobes
        bus2.BtnRun = 1'b1;
        n = 0;
        while (!bus2.Running && n < 20) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("fast_running", bus2.Running, 1'b1);
        chk("fast_count0", bus2.StepCount, 16'd0);
        ones = 0;
        for (int k = 1; k <= 65537; k++) begin
            @(posedge Clk);
            #1;
            if (bus2.ClkEn) ones++;
            if (k == 1)     chk("fast_first", bus2.StepCount, 16'd1);
            if (k == 65535) chk("fast_max", bus2.StepCount, 16'hFFFF);
            if (k == 65536) chk("fast_wrap", bus2.StepCount, 16'h0000);
        end
        chk("fast_continuous", ones, 65537);
        chk("fast_still_running", bus2.Running, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
